// File: rtl/mcp3008_scanner.sv
// Round-robin single-ended scanner for the MCP3008 ADC (SPI mode 0). Each conversion is
// delivered on a valid/ready stream and also stored in a per-channel result bank.
module mcp3008_scanner #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  CH_MASK    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso,
  output logic [9:0]  result_tdata,
  output logic [2:0]  result_tchannel,
  output logic        result_tvalid,
  input  logic        result_tready,
  output logic [79:0] ch_data,
  output logic        scan_done
);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StStall} state_e;

  function automatic logic [2:0] lowest_ch(input logic [7:0] mask);
    lowest_ch = 3'd0;
    for (int i = 7; i >= 0; i--) if (mask[i]) lowest_ch = 3'(i);
  endfunction

  function automatic logic [2:0] highest_ch(input logic [7:0] mask);
    highest_ch = 3'd0;
    for (int i = 0; i < 8; i++) if (mask[i]) highest_ch = 3'(i);
  endfunction

  // Smallest forward offset wins; an offset of 8 (the channel itself) is the fallback.
  function automatic logic [2:0] next_ch(input logic [2:0] cur);
    next_ch = cur;
    for (int i = 7; i >= 1; i--) begin
      if (CH_MASK[3'(cur + 3'(i))]) next_ch = 3'(cur + 3'(i));
    end
  endfunction

  function automatic logic mosi_bit(input logic [4:0] period, input logic [2:0] ch);
    case (period)
      5'd0, 5'd1: mosi_bit = 1'b1;
      5'd2:       mosi_bit = ch[2];
      5'd3:       mosi_bit = ch[1];
      5'd4:       mosi_bit = ch[0];
      default:    mosi_bit = 1'b0;
    endcase
  endfunction

  localparam logic [2:0] FirstCh = lowest_ch(CH_MASK);
  localparam logic [2:0] LastCh  = highest_ch(CH_MASK);
  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  period_q, period_d;
  logic [7:0]  gap_q, gap_d;
  logic [2:0]  ch_q, ch_d;
  logic [9:0]  shreg_q, shreg_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic [9:0]  tdata_q, tdata_d;
  logic [2:0]  tchan_q, tchan_d;
  logic        tvalid_q, tvalid_d;
  logic [79:0] ch_data_q, ch_data_d;
  logic        done_q, done_d;
  logic        accept;
  logic        exit_gap;
  logic        start_frame;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    period_d    = period_q;
    gap_d       = gap_q;
    ch_d        = ch_q;
    shreg_d     = shreg_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    tdata_d     = tdata_q;
    tchan_d     = tchan_q;
    tvalid_d    = tvalid_q;
    ch_data_d   = ch_data_q;
    done_d      = 1'b0;
    exit_gap    = 1'b0;
    start_frame = 1'b0;

    accept = tvalid_q & result_tready;
    if (accept) tvalid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && (CH_MASK != 8'd0)) start_frame = 1'b1;
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            // Periods 5-6 carry the sample/null bits; data is B9..B0 in periods 7-16.
            if (period_q >= 5'd7) shreg_d = {shreg_q[8:0], miso};
          end else begin
            sclk_d = 1'b0;
            if (period_q == 5'd16) begin
              state_d  = StGap;
              cs_n_d   = 1'b1;
              mosi_d   = 1'b0;
              gap_d    = 8'd0;
              tdata_d  = shreg_q;
              tchan_d  = ch_q;
              tvalid_d = 1'b1;
              for (int n = 0; n < 8; n++) begin
                if (ch_q == 3'(n)) ch_data_d[10*n +: 10] = shreg_q;
              end
              done_d = (ch_q == LastCh);
              ch_d   = next_ch(ch_q);
            end else begin
              period_d = period_q + 5'd1;
              mosi_d   = mosi_bit(period_q + 5'd1, ch_q);
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) exit_gap = 1'b1;
        else gap_d = gap_q + 8'd1;
      end
      StStall: begin
        if (accept) exit_gap = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // A new frame only starts once the previous result has left, so nothing is overwritten.
    if (exit_gap) begin
      if (tvalid_q && !accept) state_d = StStall;
      else if (enable)         start_frame = 1'b1;
      else                     state_d = StIdle;
    end

    if (start_frame) begin
      state_d  = StShift;
      cs_n_d   = 1'b0;
      sclk_d   = 1'b0;
      mosi_d   = mosi_bit(5'd0, ch_q);
      div_d    = 8'd0;
      period_d = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_q     <= 8'd0;
      period_q  <= 5'd0;
      gap_q     <= 8'd0;
      ch_q      <= FirstCh;
      shreg_q   <= 10'd0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      tdata_q   <= 10'd0;
      tchan_q   <= 3'd0;
      tvalid_q  <= 1'b0;
      ch_data_q <= 80'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      period_q  <= period_d;
      gap_q     <= gap_d;
      ch_q      <= ch_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      tdata_q   <= tdata_d;
      tchan_q   <= tchan_d;
      tvalid_q  <= tvalid_d;
      ch_data_q <= ch_data_d;
      done_q    <= done_d;
    end
  end

  assign sclk            = sclk_q;
  assign cs_n            = cs_n_q;
  assign mosi            = mosi_q;
  assign result_tdata    = tdata_q;
  assign result_tchannel = tchan_q;
  assign result_tvalid   = tvalid_q;
  assign ch_data         = ch_data_q;
  assign scan_done       = done_q;

endmodule

// File: tb/tb_mcp3008_scanner.sv
// Directed bench for mcp3008_scanner: two instances (all channels, channels 1 and 5) each
// driven by a behavioural MCP3008 model.
module tb_mcp3008_scanner;

  logic        clk;
  logic        rst_n;
  logic        enable_a, enable_b;
  logic        tready_a, tready_b;
  logic        sclk_a, sclk_b, cs_a, cs_b, mosi_a, mosi_b, miso_a, miso_b;
  logic [9:0]  tdata_a, tdata_b;
  logic [2:0]  tch_a, tch_b;
  logic        tvalid_a, tvalid_b;
  logic [79:0] ch_data_a, ch_data_b;
  logic        done_a, done_b;

  int checks = 0;
  int errors = 0;

  logic [9:0] tbl_a [8];
  logic [9:0] tbl_b [8];

  int         flen [2];
  int         rises [2];
  int         last_len [2];
  int         last_rises [2];
  logic [4:0] cmd [2];
  logic [4:0] last_cmd [2];
  logic       sclk_p [2];

  logic [2:0] qch_a [$];
  logic [9:0] qd_a [$];
  logic [2:0] qch_b [$];
  logic [9:0] qd_b [$];
  int         done_cnt_a;
  int         done_cnt_b;
  logic [2:0] done_ch_a;

  mcp3008_scanner #(.CLK_DIV(2), .GAP_CYCLES(4), .CH_MASK(8'hFF)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .sclk(sclk_a), .cs_n(cs_a), .mosi(mosi_a),
    .miso(miso_a), .result_tdata(tdata_a), .result_tchannel(tch_a), .result_tvalid(tvalid_a),
    .result_tready(tready_a), .ch_data(ch_data_a), .scan_done(done_a)
  );

  mcp3008_scanner #(.CLK_DIV(2), .GAP_CYCLES(4), .CH_MASK(8'b0010_0010)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .sclk(sclk_b), .cs_n(cs_b), .mosi(mosi_b),
    .miso(miso_b), .result_tdata(tdata_b), .result_tchannel(tch_b), .result_tvalid(tvalid_b),
    .result_tready(tready_b), .ch_data(ch_data_b), .scan_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model plus result logging, evaluated on the falling clock edge.
  initial begin : adc_model
    logic       s, c, m, mv;
    logic [9:0] v;
    done_cnt_a = 0;
    done_cnt_b = 0;
    done_ch_a  = 3'd0;
    miso_a     = 1'b0;
    miso_b     = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        s  = (g == 0) ? sclk_a : sclk_b;
        c  = (g == 0) ? cs_a : cs_b;
        m  = (g == 0) ? mosi_a : mosi_b;
        mv = 1'b0;
        if (c !== 1'b0) begin
          if (flen[g] != 0) begin
            last_len[g]   = flen[g];
            last_rises[g] = rises[g];
            last_cmd[g]   = cmd[g];
          end
          flen[g]  = 0;
          rises[g] = 0;
          cmd[g]   = 5'd0;
        end else begin
          flen[g]++;
          if (s === 1'b1 && sclk_p[g] === 1'b0) begin
            if (rises[g] < 5) cmd[g] = {cmd[g][3:0], m};
            rises[g]++;
          end
          if (s === 1'b0) begin
            v = (g == 0) ? tbl_a[cmd[g][2:0]] : tbl_b[cmd[g][2:0]];
            if (rises[g] >= 7 && rises[g] <= 16) mv = v[16 - rises[g]];
          end else begin
            mv = (g == 0) ? miso_a : miso_b;
          end
        end
        if (g == 0) miso_a = mv;
        else        miso_b = mv;
        sclk_p[g] = s;
      end
      if (tvalid_a === 1'b1 && tready_a === 1'b1) begin
        qch_a.push_back(tch_a);
        qd_a.push_back(tdata_a);
      end
      if (tvalid_b === 1'b1 && tready_b === 1'b1) begin
        qch_b.push_back(tch_b);
        qd_b.push_back(tdata_b);
      end
      if (done_a === 1'b1) begin
        done_cnt_a++;
        done_ch_a = tch_a;
      end
      if (done_b === 1'b1) done_cnt_b++;
    end
  end

  task automatic set_tbl_a(input int base);
    for (int n = 0; n < 8; n++) tbl_a[n] = 10'(64 * n + base);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    qch_a.delete();
    qd_a.delete();
    qch_b.delete();
    qd_b.delete();
    done_cnt_a = 0;
    done_cnt_b = 0;
  endtask

  task automatic wait_results(input int sel, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if ((sel == 0 && qch_a.size() >= n) || (sel == 1 && qch_b.size() >= n)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_period_a(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (cs_a === 1'b0 && rises[0] == p && sclk_a === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    tready_a = 1'b1;
    tready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk_a); end
    checks++; if (cs_a !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_a); end
    checks++; if (mosi_a !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi_a); end
    checks++; if (tvalid_a !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid_a); end
    checks++; if (tdata_a !== 10'd0) begin errors++; $display("FAIL reset_tdata got %h want 0", tdata_a); end
    checks++; if (tch_a !== 3'd0) begin errors++; $display("FAIL reset_tchannel got %0d want 0", tch_a); end
    checks++; if (ch_data_a !== 80'd0) begin errors++; $display("FAIL reset_ch_data got %h want 0", ch_data_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_scan_done got %b want 0", done_a); end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (cs_a !== 1'b1) begin errors++; $display("FAIL idle_cs_n got %b want 1", cs_a); end
  endtask

  task automatic test_channel3();
    bit ok;
    do_reset();
    set_tbl_a(0);
    tbl_a[3] = 10'h2A5;
    tready_a = 1'b1;
    enable_a = 1'b1;
    wait_results(0, 4, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ch3_timeout got %0d results want 4", qch_a.size()); end
    if (ok) begin
      checks++; if (qch_a[3] !== 3'd3) begin errors++; $display("FAIL ch3_tchannel got %0d want 3", qch_a[3]); end
      checks++; if (qd_a[3] !== 10'h2A5) begin errors++; $display("FAIL ch3_tdata got %h want 2a5", qd_a[3]); end
      checks++; if (last_len[0] != 68) begin errors++; $display("FAIL ch3_cs_low_cycles got %0d want 68", last_len[0]); end
      checks++; if (last_rises[0] != 17) begin errors++; $display("FAIL ch3_sclk_rises got %0d want 17", last_rises[0]); end
      checks++; if (last_cmd[0] !== 5'b11011) begin errors++; $display("FAIL ch3_mosi_bits got %b want 11011", last_cmd[0]); end
      checks++; if (ch_data_a[39:30] !== 10'h2A5) begin errors++; $display("FAIL ch3_ch_data got %h want 2a5", ch_data_a[39:30]); end
    end
  endtask

  task automatic test_full_scan();
    bit ok;
    logic [2:0] ech;
    do_reset();
    set_tbl_a(0);
    tready_a = 1'b1;
    enable_a = 1'b1;
    wait_results(0, 9, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan_timeout got %0d results want 9", qch_a.size()); end
    if (ok) begin
      for (int i = 0; i < 9; i++) begin
        ech = 3'(i % 8);
        checks++; if (qch_a[i] !== ech) begin errors++; $display("FAIL scan_tchannel[%0d] got %0d want %0d", i, qch_a[i], ech); end
        checks++; if (qd_a[i] !== 10'(64 * (i % 8))) begin errors++; $display("FAIL scan_tdata[%0d] got %h want %h", i, qd_a[i], 10'(64 * (i % 8))); end
      end
      checks++; if (done_cnt_a != 1) begin errors++; $display("FAIL scan_done_count got %0d want 1", done_cnt_a); end
      checks++; if (done_ch_a !== 3'd7) begin errors++; $display("FAIL scan_done_channel got %0d want 7", done_ch_a); end
      for (int n = 0; n < 8; n++) begin
        checks++; if (ch_data_a[10*n +: 10] !== 10'(64 * n)) begin errors++; $display("FAIL scan_ch_data[%0d] got %h want %h", n, ch_data_a[10*n +: 10], 10'(64 * n)); end
      end
    end
    enable_a = 1'b0;
  endtask

  task automatic test_mask();
    bit ok;
    logic [2:0]  ech;
    logic [79:0] exp_bank;
    do_reset();
    for (int n = 0; n < 8; n++) tbl_b[n] = 10'(10'h3C0 + n);
    tready_b = 1'b1;
    enable_b = 1'b1;
    wait_results(1, 4, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_timeout got %0d results want 4", qch_b.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        ech = (i % 2 == 0) ? 3'd1 : 3'd5;
        checks++; if (qch_b[i] !== ech) begin errors++; $display("FAIL mask_tchannel[%0d] got %0d want %0d", i, qch_b[i], ech); end
        checks++; if (qd_b[i] !== 10'(10'h3C0 + ech)) begin errors++; $display("FAIL mask_tdata[%0d] got %h want %h", i, qd_b[i], 10'(10'h3C0 + ech)); end
      end
      exp_bank = 80'd0;
      exp_bank[19:10] = 10'h3C1;
      exp_bank[59:50] = 10'h3C5;
      checks++; if (ch_data_b[9:0] !== 10'd0) begin errors++; $display("FAIL mask_field0 got %h want 0", ch_data_b[9:0]); end
      checks++; if (ch_data_b !== exp_bank) begin errors++; $display("FAIL mask_ch_data got %h want %h", ch_data_b, exp_bank); end
      checks++; if (done_cnt_b != 2) begin errors++; $display("FAIL mask_scan_done got %0d want 2", done_cnt_b); end
    end
    enable_b = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    do_reset();
    set_tbl_a(10'h300);
    tready_a = 1'b0;
    enable_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (tvalid_a === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL stall_first_valid got %b want 1", tvalid_a); end
    checks++; if (tdata_a !== 10'h300) begin errors++; $display("FAIL stall_tdata got %h want 300", tdata_a); end
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (cs_a !== 1'b1 || tvalid_a !== 1'b1 || tdata_a !== 10'h300 || tch_a !== 3'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    tready_a = 1'b1;
    wait_results(0, 3, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_resume_timeout got %0d results want 3", qch_a.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (qch_a[i] !== 3'(i)) begin errors++; $display("FAIL stall_order[%0d] got %0d want %0d", i, qch_a[i], i); end
        checks++; if (qd_a[i] !== 10'(10'h300 + 64 * i)) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", i, qd_a[i], 10'(10'h300 + 64 * i)); end
      end
    end
    enable_a = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit ok;
    do_reset();
    set_tbl_a(0);
    tready_a = 1'b1;
    enable_a = 1'b1;
    wait_results(0, 2, 1000, ok);
    if (ok) wait_period_a(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_reach_period8 got %0d results want 2", qch_a.size()); end
    enable_a = 1'b0;
    wait_results(0, 3, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_finish_timeout got %0d results want 3", qch_a.size()); end
    if (ok) begin
      checks++; if (qch_a[2] !== 3'd2) begin errors++; $display("FAIL drop_tchannel got %0d want 2", qch_a[2]); end
      checks++; if (qd_a[2] !== 10'h080) begin errors++; $display("FAIL drop_tdata got %h want 080", qd_a[2]); end
    end
    repeat (100) @(posedge clk);
    #1;
    checks++; if (qch_a.size() != 3) begin errors++; $display("FAIL drop_idle_results got %0d want 3", qch_a.size()); end
    checks++; if (cs_a !== 1'b1) begin errors++; $display("FAIL drop_idle_cs_n got %b want 1", cs_a); end
    enable_a = 1'b1;
    wait_results(0, 4, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_resume_timeout got %0d results want 4", qch_a.size()); end
    if (ok) begin
      checks++; if (qch_a[3] !== 3'd3) begin errors++; $display("FAIL drop_resume_channel got %0d want 3", qch_a[3]); end
      checks++; if (qd_a[3] !== 10'h0C0) begin errors++; $display("FAIL drop_resume_tdata got %h want 0c0", qd_a[3]); end
    end
    enable_a = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int n_before;
    do_reset();
    set_tbl_a(5);
    tready_a = 1'b1;
    enable_a = 1'b1;
    wait_results(0, 2, 1000, ok);
    if (ok) wait_period_a(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach_period10 got %0d results want 2", qch_a.size()); end
    n_before = qch_a.size();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (cs_a !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n got %b want 1", cs_a); end
    checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk got %b want 0", sclk_a); end
    checks++; if (tvalid_a !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid got %b want 0", tvalid_a); end
    checks++; if (ch_data_a !== 80'd0) begin errors++; $display("FAIL rst_mid_ch_data got %h want 0", ch_data_a); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_results(0, n_before + 1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_restart_timeout got %0d results want %0d", qch_a.size(), n_before + 1); end
    if (ok) begin
      checks++; if (qch_a[n_before] !== 3'd0) begin errors++; $display("FAIL rst_restart_channel got %0d want 0", qch_a[n_before]); end
      checks++; if (qd_a[n_before] !== 10'h005) begin errors++; $display("FAIL rst_restart_tdata got %h want 005", qd_a[n_before]); end
    end
    enable_a = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    tready_a = 1'b1;
    tready_b = 1'b1;
    set_tbl_a(0);
    for (int n = 0; n < 8; n++) tbl_b[n] = 10'd0;
    test_reset();
    test_channel3();
    test_full_scan();
    test_mask();
    test_stall();
    test_enable_drop();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
